// File: rtl/enemy_controller.sv
// enemy_controller: owns the enemy slot table. A frame tick starts a sweep that moves every
// active enemy down by its speed and retires escapees. A spawn step then places a new enemy
// from an LFSR into the lowest free slot each SPAWN_PERIOD frames. Bullet hits are taken only
// while idle.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   enable_i               game running; low freezes movement/spawning (hits still taken)
//   frame_tick_i           one-cycle pulse per frame
//   hit_valid_i/slot_i     bullet hit report; accepted when hit_ready_o is high
//   hit_ready_o            high only in the idle state
//   sel_slot_i             slot presented on the sel_* read port (combinational)
//   active_mask_o          bit i = slot i occupied
//   kill_pulse_o/type_o    registered pulse when an enemy's health reaches 0
//   escape_pulse_o         registered pulse when an enemy passes Y_LIMIT
module enemy_controller #(
   parameter int unsigned N_SLOTS      = 4,
   parameter int unsigned SPAWN_PERIOD = 120,
   parameter int unsigned Y_SPAWN      = 8,
   parameter int unsigned Y_LIMIT      = 472,
   localparam int unsigned SW          = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               frame_tick_i,
   input  logic               hit_valid_i,
   input  logic [SW-1:0]      hit_slot_i,
   output logic               hit_ready_o,
   input  logic [SW-1:0]      sel_slot_i,
   output logic               sel_active_o,
   output logic [1:0]         sel_type_o,
   output logic [3:0]         sel_health_o,
   output logic [9:0]         sel_x_o,
   output logic [9:0]         sel_y_o,
   output logic [N_SLOTS-1:0] active_mask_o,
   output logic               kill_pulse_o,
   output logic [1:0]         kill_type_o,
   output logic               escape_pulse_o
);

   localparam int unsigned CW  = $clog2(SPAWN_PERIOD + 1);
   localparam int unsigned SIW = SW + 1;

   typedef enum logic [1:0] {StIdle, StSweep, StSpawn} state_e;

   state_e                   state_q, state_d;
   logic [SW-1:0]            idx_q, idx_d;
   logic                     pending_q, pending_d;
   logic [CW-1:0]            spawn_cnt_q, spawn_cnt_d;
   logic [15:0]              lfsr_q;
   logic [N_SLOTS-1:0]       active_q, active_d;
   logic [N_SLOTS-1:0][1:0]  type_q, type_d;
   logic [N_SLOTS-1:0][3:0]  health_q, health_d;
   logic [N_SLOTS-1:0][9:0]  x_q, x_d;
   logic [N_SLOTS-1:0][9:0]  y_q, y_d;
   logic                     kill_pulse_q, kill_pulse_d;
   logic [1:0]               kill_type_q, kill_type_d;
   logic                     escape_q, escape_d;

   logic [9:0]               y_new;
   logic                     free_found;
   logic [SW-1:0]            free_idx;
   logic [1:0]               spawn_type;
   logic [3:0]               spawn_health;
   logic                     start_sweep;

   function automatic logic [9:0] speed_of(input logic [1:0] t);
      return (t == 2'd0) ? 10'd2 : 10'd1;
   endfunction

   // Lowest-index free slot: scan downwards so the last hit wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            free_found = 1'b1;
            free_idx   = SW'(i);
         end
      end
   end

   always_comb begin
      unique case (lfsr_q[1:0])
         2'd1: begin
            spawn_type   = 2'd1;
            spawn_health = 4'd4;
         end
         2'd2: begin
            spawn_type   = 2'd2;
            spawn_health = 4'd2;
         end
         default: begin
            spawn_type   = 2'd0;
            spawn_health = 4'd1;
         end
      endcase
   end

   // A queued tick counts the same as a live one when deciding to start a sweep.
   assign start_sweep = enable_i && (frame_tick_i || pending_q);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pending_d    = pending_q;
      spawn_cnt_d  = spawn_cnt_q;
      active_d     = active_q;
      type_d       = type_q;
      health_d     = health_q;
      x_d          = x_q;
      y_d          = y_q;
      kill_pulse_d = 1'b0;
      kill_type_d  = kill_type_q;
      escape_d     = 1'b0;
      y_new        = y_q[idx_q];

      unique case (state_q)
         StIdle: begin
            if (hit_valid_i && ({1'b0, hit_slot_i} < SIW'(N_SLOTS)) && active_q[hit_slot_i]) begin
               health_d[hit_slot_i] = health_q[hit_slot_i] - 4'd1;
               if (health_q[hit_slot_i] == 4'd1) begin
                  active_d[hit_slot_i] = 1'b0;
                  kill_pulse_d         = 1'b1;
                  kill_type_d          = type_q[hit_slot_i];
               end
            end
            if (start_sweep) begin
               state_d   = StSweep;
               idx_d     = '0;
               pending_d = 1'b0;
            end
         end
         StSweep: begin
            if (active_q[idx_q]) begin
               y_new      = y_q[idx_q] + speed_of(type_q[idx_q]);
               y_d[idx_q] = y_new;
               if (y_new >= 10'(Y_LIMIT)) begin
                  active_d[idx_q] = 1'b0;
                  escape_d        = 1'b1;
               end
            end
            if (frame_tick_i && enable_i) begin
               pending_d = 1'b1;
            end
            if (idx_q == SW'(N_SLOTS - 1)) begin
               state_d = StSpawn;
            end else begin
               idx_d = idx_q + SW'(1);
            end
         end
         StSpawn: begin
            if (spawn_cnt_q <= CW'(1)) begin
               if (free_found) begin
                  active_d[free_idx] = 1'b1;
                  type_d[free_idx]   = spawn_type;
                  health_d[free_idx] = spawn_health;
                  x_d[free_idx]      = 10'd64 + {1'b0, lfsr_q[10:2]};
                  y_d[free_idx]      = 10'(Y_SPAWN);
                  spawn_cnt_d        = CW'(SPAWN_PERIOD);
               end else begin
                  // Table full: park at 0 so the next frame retries.
                  spawn_cnt_d = '0;
               end
            end else begin
               spawn_cnt_d = spawn_cnt_q - CW'(1);
            end
            if (start_sweep) begin
               state_d   = StSweep;
               idx_d     = '0;
               pending_d = 1'b0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         pending_q    <= 1'b0;
         spawn_cnt_q  <= CW'(SPAWN_PERIOD);
         lfsr_q       <= 16'hACE1;
         active_q     <= '0;
         type_q       <= '0;
         health_q     <= '0;
         x_q          <= '0;
         y_q          <= '0;
         kill_pulse_q <= 1'b0;
         kill_type_q  <= 2'd0;
         escape_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         spawn_cnt_q  <= spawn_cnt_d;
         lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         active_q     <= active_d;
         type_q       <= type_d;
         health_q     <= health_d;
         x_q          <= x_d;
         y_q          <= y_d;
         kill_pulse_q <= kill_pulse_d;
         kill_type_q  <= kill_type_d;
         escape_q     <= escape_d;
      end
   end

   always_comb begin
      sel_active_o = 1'b0;
      sel_type_o   = 2'd0;
      sel_health_o = 4'd0;
      sel_x_o      = 10'd0;
      sel_y_o      = 10'd0;
      if ({1'b0, sel_slot_i} < SIW'(N_SLOTS)) begin
         sel_active_o = active_q[sel_slot_i];
         sel_type_o   = type_q[sel_slot_i];
         sel_health_o = health_q[sel_slot_i];
         sel_x_o      = x_q[sel_slot_i];
         sel_y_o      = y_q[sel_slot_i];
      end
   end

   assign hit_ready_o    = (state_q == StIdle);
   assign active_mask_o  = active_q;
   assign kill_pulse_o   = kill_pulse_q;
   assign kill_type_o    = kill_type_q;
   assign escape_pulse_o = escape_q;

endmodule

// File: tb/tb_enemy_controller.sv
// Directed bench for enemy_controller with a per-frame reference model of the slot table.
module tb_enemy_controller;

   localparam int N  = 4;
   localparam int P  = 3;
   localparam int YS = 8;
   localparam int YL = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       frame_tick;
   logic       hit_valid;
   logic [1:0] hit_slot;
   logic       hit_ready;
   logic [1:0] sel_slot;
   logic       sel_active;
   logic [1:0] sel_type;
   logic [3:0] sel_health;
   logic [9:0] sel_x;
   logic [9:0] sel_y;
   logic [3:0] active_mask;
   logic       kill_pulse;
   logic [1:0] kill_type;
   logic       escape_pulse;

   enemy_controller #(
      .N_SLOTS      (N),
      .SPAWN_PERIOD (P),
      .Y_SPAWN      (YS),
      .Y_LIMIT      (YL)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .frame_tick_i   (frame_tick),
      .hit_valid_i    (hit_valid),
      .hit_slot_i     (hit_slot),
      .hit_ready_o    (hit_ready),
      .sel_slot_i     (sel_slot),
      .sel_active_o   (sel_active),
      .sel_type_o     (sel_type),
      .sel_health_o   (sel_health),
      .sel_x_o        (sel_x),
      .sel_y_o        (sel_y),
      .active_mask_o  (active_mask),
      .kill_pulse_o   (kill_pulse),
      .kill_type_o    (kill_type),
      .escape_pulse_o (escape_pulse)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int          m_act[N];
   int          m_typ[N];
   int          m_hp[N];
   int          m_x[N];
   int          m_y[N];
   int          m_cnt;
   int          m_esc  = 0;
   int          m_kill = 0;
   int          m_ktype;
   logic [15:0] m_lfsr;
   int          d_esc  = 0;
   int          d_kill = 0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= lfsr_step(m_lfsr);
   end

   always @(posedge clk) begin
      if (escape_pulse === 1'b1) d_esc <= d_esc + 1;
      if (kill_pulse === 1'b1)   d_kill <= d_kill + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_typ[i] = 0; m_hp[i] = 0; m_x[i] = 0; m_y[i] = 0;
      end
      m_cnt = P;
   endtask

   task automatic model_frame(input logic [15:0] sp);
      int fi;
      for (int i = 0; i < N; i++) begin
         if (m_act[i] != 0) begin
            m_y[i] = m_y[i] + ((m_typ[i] == 0) ? 2 : 1);
            if (m_y[i] >= YL) begin
               m_act[i] = 0;
               m_esc++;
            end
         end
      end
      if (m_cnt <= 1) begin
         fi = -1;
         for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) fi = i;
         if (fi >= 0) begin
            m_typ[fi] = (sp[1:0] == 2'd1) ? 1 : (sp[1:0] == 2'd2) ? 2 : 0;
            m_hp[fi]  = (m_typ[fi] == 1) ? 4 : (m_typ[fi] == 2) ? 2 : 1;
            m_x[fi]   = 64 + int'(sp[10:2]);
            m_y[fi]   = YS;
            m_act[fi] = 1;
            m_cnt     = P;
         end else begin
            m_cnt = 0;
         end
      end else begin
         m_cnt--;
      end
   endtask

   task automatic model_hit(input int s, output int killed);
      killed = 0;
      if (m_act[s] != 0) begin
         m_hp[s]--;
         if (m_hp[s] == 0) begin
            m_act[s] = 0;
            m_kill++;
            m_ktype = m_typ[s];
            killed  = 1;
         end
      end
   endtask

   task automatic check_table();
      int mask;
      mask = 0;
      for (int i = 0; i < N; i++) begin
         sel_slot = 2'(i);
         #1;
         chk($sformatf("slot%0d_active", i), sel_active, m_act[i]);
         chk($sformatf("slot%0d_type", i), sel_type, m_typ[i]);
         chk($sformatf("slot%0d_health", i), sel_health, m_hp[i]);
         chk($sformatf("slot%0d_x", i), sel_x, m_x[i]);
         chk($sformatf("slot%0d_y", i), sel_y, m_y[i]);
         if (m_act[i] != 0) mask = mask | (1 << i);
      end
      chk("active_mask", active_mask, mask);
   endtask

   // Tick issued in IDLE; the spawn step samples the LFSR N+1 cycles later.
   task automatic do_frame();
      logic [15:0] sp;
      sp = lfsr_adv(m_lfsr, N + 1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("ready_low_sweep", hit_ready, 0);
      for (int j = 0; j < N + 1; j++) step();
      chk("ready_back_idle", hit_ready, 1);
      model_frame(sp);
      chk("escape_count", d_esc, m_esc);
      chk("no_kill_in_frame", d_kill, m_kill);
   endtask

   task automatic do_hit(input int s);
      int killed;
      hit_valid = 1'b1;
      hit_slot  = 2'(s);
      chk("hit_ready_idle", hit_ready, 1);
      step();
      hit_valid = 1'b0;
      model_hit(s, killed);
      chk("kill_pulse", kill_pulse, killed);
      if (killed != 0) chk("kill_type", kill_type, m_ktype);
      step();
      chk("kill_pulse_one_cycle", kill_pulse, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] pv;
      logic [15:0] sp1;
      logic [15:0] sp2;
      int          killed;

      rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; hit_valid = 1'b0;
      hit_slot = 2'd0; sel_slot = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hit_ready", hit_ready, 1);
      chk("rst_kill_pulse", kill_pulse, 0);
      chk("rst_kill_type", kill_type, 0);
      chk("rst_escape", escape_pulse, 0);
      check_table();
      @(posedge clk);
      #1;
      rst = 1'b0;
      enable = 1'b1;

      // Two frames with no spawn (counter 3 -> 2 -> 1).
      do_frame();
      do_frame();
      chk("no_spawn_yet", active_mask, 0);

      // Wait until the spawn step will see a type-1 LFSR value.
      pv = lfsr_adv(m_lfsr, N + 1);
      for (int w = 0; w < 64; w++) begin
         if (pv[1:0] == 2'd1) break;
         step();
         pv = lfsr_adv(m_lfsr, N + 1);
      end
      do_frame();
      sel_slot = 2'd0;
      #1;
      chk("spawn_active", sel_active, 1);
      chk("spawn_type", sel_type, 1);
      chk("spawn_health", sel_health, 4);
      chk("spawn_y", sel_y, YS);
      chk("spawn_x", sel_x, 64 + int'(pv[10:2]));
      chk("spawn_mask", active_mask, 4'b0001);
      check_table();

      do_frame();
      sel_slot = 2'd0;
      #1;
      chk("move_y", sel_y, YS + 1);

      // Four hits kill the type-1 enemy.
      do_hit(0);
      sel_slot = 2'd0; #1; chk("hit1_health", sel_health, 3);
      do_hit(0);
      sel_slot = 2'd0; #1; chk("hit2_health", sel_health, 2);
      do_hit(0);
      sel_slot = 2'd0; #1; chk("hit3_health", sel_health, 1);
      do_hit(0);
      chk("kill_mask", active_mask, 0);
      chk("kill_count", d_kill, 1);

      // Respawn into slot 0, then hit it while a sweep is running.
      for (int f = 0; f < 6 && m_act[0] == 0; f++) do_frame();
      chk("respawn_slot0", active_mask[0], 1);
      sp1 = lfsr_adv(m_lfsr, N + 1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      hit_valid = 1'b1;
      hit_slot  = 2'd0;
      for (int j = 0; j < N + 1; j++) begin
         chk("busy_ready_low", hit_ready, 0);
         step();
      end
      chk("busy_ready_high", hit_ready, 1);
      model_frame(sp1);
      step();
      hit_valid = 1'b0;
      model_hit(0, killed);
      chk("late_hit_kill", kill_pulse, killed);
      step();
      check_table();

      // Fill the table, then let the counter run down to zero.
      for (int f = 0; f < 40 && active_mask != 4'hF; f++) do_frame();
      chk("fill_mask", active_mask, 4'hF);
      repeat (3) do_frame();
      chk("full_no_spawn", active_mask, 4'hF);
      check_table();
      for (int h = 0; h < 8 && m_act[2] != 0; h++) do_hit(2);
      chk("slot2_killed", active_mask, 4'b1011);
      do_frame();
      chk("spawn_into_slot2", active_mask, 4'hF);
      check_table();

      // Run until something escapes.
      for (int f = 0; f < 120 && m_esc == 0; f++) do_frame();
      chk("escape_seen", d_esc != 0, 1);
      check_table();

      // Three ticks during one frame -> exactly one extra sweep.
      sp1 = lfsr_adv(m_lfsr, N + 1);
      sp2 = lfsr_adv(m_lfsr, 2 * N + 2);
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      for (int j = 0; j < N + 2; j++) begin
         chk("double_busy", hit_ready, 0);
         step();
      end
      chk("double_idle", hit_ready, 1);
      model_frame(sp1);
      model_frame(sp2);
      repeat (3) step();
      chk("no_third_sweep", hit_ready, 1);
      chk("double_escapes", d_esc, m_esc);
      check_table();

      // Reset in the middle of a sweep.
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_hit_ready", hit_ready, 1);
      chk("midrst_kill_pulse", kill_pulse, 0);
      chk("midrst_kill_type", kill_type, 0);
      chk("midrst_escape", escape_pulse, 0);
      check_table();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) do_frame();
      chk("post_rst_spawn", active_mask, 4'b0001);
      check_table();

      chk("esc_total", d_esc, m_esc);
      chk("kill_total", d_kill, m_kill);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
